// File: rtl/axi_write_arbiter_if.sv
// Bundles the NUM_M master-side and single slave-side AXI write channels (AW/W/B).
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface axi_write_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [NUM_M*ADDR_W-1:0] M_AWADDR;
  logic [NUM_M*13-1:0]     M_AWCTL;
  logic [NUM_M-1:0]        M_AWVALID;
  logic [NUM_M-1:0]        M_AWREADY;
  logic [NUM_M*DATA_W-1:0] M_WDATA;
  logic [NUM_M-1:0]        M_WLAST;
  logic [NUM_M-1:0]        M_WVALID;
  logic [NUM_M-1:0]        M_WREADY;
  logic [NUM_M*2-1:0]      M_BRESP;
  logic [NUM_M-1:0]        M_BVALID;
  logic [NUM_M-1:0]        M_BREADY;

  logic [ADDR_W-1:0]       S_AWADDR;
  logic [12:0]             S_AWCTL;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_W-1:0]       S_WDATA;
  logic                    S_WLAST;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;

  modport slave (
    input  M_AWADDR, M_AWCTL, M_AWVALID, M_WDATA, M_WLAST, M_WVALID, M_BREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    output S_AWADDR, S_AWCTL, S_AWVALID, S_WDATA, S_WLAST, S_WVALID, S_BREADY
  );

  modport master (
    output M_AWADDR, M_AWCTL, M_AWVALID, M_WDATA, M_WLAST, M_WVALID, M_BREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    input  S_AWADDR, S_AWCTL, S_AWVALID, S_WDATA, S_WLAST, S_WVALID, S_BREADY
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write slave between NUM_M masters; the winner owns AW/W/B.
// Optional beat-count checking is built when AXI_ARB_BEAT_CHECK_EN is defined.
//
// state   | meaning
// ST_IDLE | no owner; pick next requester round-robin from rr_ptr+1
// ST_AW   | forward granted master's AW to the slave
// ST_W    | forward granted master's W beats until WLAST handshake
// ST_B    | return slave response to granted master
module axi_write_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  axi_write_arbiter_if.slave   bus,
  output logic [NUM_M-1:0]     GRANT,
  output logic                 BUSY,
  output logic                 BEAT_ERR
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_M-1:0]  r_grant;
  logic [IDX_W-1:0]  r_gidx;
  logic [IDX_W-1:0]  r_rr_ptr;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_cand;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wlast;
  logic              w_b_hs;
  logic              w_err;

  assign w_aw_hs = (r_state == ST_AW) && bus.M_AWVALID[r_gidx] && bus.S_AWREADY;
  assign w_w_hs  = (r_state == ST_W)  && bus.M_WVALID[r_gidx]  && bus.S_WREADY;
  assign w_wlast = bus.M_WLAST[r_gidx];
  assign w_b_hs  = (r_state == ST_B)  && bus.S_BVALID && bus.M_BREADY[r_gidx];

  assign GRANT = r_grant;
  assign BUSY  = (r_state != ST_IDLE);

  // Search starts one past the last owner so every requester is reached within NUM_M-1 grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_M);
      if (!w_found && bus.M_AWVALID[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= IDX_W'(NUM_M - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_grant <= NUM_M'(1) << w_win;
        r_gidx  <= w_win;
      end
      if (w_b_hs) begin
        r_grant  <= '0;
        r_rr_ptr <= r_gidx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.S_AWADDR  = '0;
    bus.S_AWCTL   = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_WDATA   = '0;
    bus.S_WLAST   = 1'b0;
    bus.S_WVALID  = 1'b0;
    bus.S_BREADY  = 1'b0;
    bus.M_AWREADY = '0;
    bus.M_WREADY  = '0;
    bus.M_BVALID  = '0;
    bus.M_BRESP   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_AW;
      end
      ST_AW: begin
        bus.S_AWADDR  = bus.M_AWADDR[r_gidx*ADDR_W +: ADDR_W];
        bus.S_AWCTL   = bus.M_AWCTL[r_gidx*13 +: 13];
        bus.S_AWVALID = bus.M_AWVALID[r_gidx];
        bus.M_AWREADY[r_gidx] = bus.S_AWREADY;
        if (w_aw_hs) w_state_nxt = ST_W;
      end
      ST_W: begin
        bus.S_WDATA  = bus.M_WDATA[r_gidx*DATA_W +: DATA_W];
        bus.S_WLAST  = w_wlast;
        bus.S_WVALID = bus.M_WVALID[r_gidx];
        bus.M_WREADY[r_gidx] = bus.S_WREADY;
        if (w_w_hs && w_wlast) w_state_nxt = ST_B;
      end
      ST_B: begin
        bus.M_BVALID[r_gidx]       = bus.S_BVALID;
        bus.M_BRESP[r_gidx*2 +: 2] = w_err ? 2'b10 : bus.S_BRESP;
        bus.S_BREADY               = bus.M_BREADY[r_gidx];
        if (w_b_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef AXI_ARB_BEAT_CHECK_EN
  logic [7:0] r_awlen;
  logic [7:0] r_beat_cnt;
  logic       r_err;

  // The count holds the index of the beat being accepted, so a correct WLAST sees count == AWLEN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_awlen    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awlen    <= bus.M_AWCTL[r_gidx*13 + 5 +: 8];
        r_beat_cnt <= '0;
      end else if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_w_hs && w_wlast && (r_beat_cnt != r_awlen)) r_err <= 1'b1;
      else if (w_b_hs) r_err <= 1'b0;
    end
  end

  assign w_err    = r_err;
  assign BEAT_ERR = w_b_hs & r_err;
`else
  assign w_err    = 1'b0;
  assign BEAT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with two masters and a cooperative slave model.
// Expectations for the beat check follow whether AXI_ARB_BEAT_CHECK_EN is defined.
module tb_axi_write_arbiter;

  logic       CLK;
  logic       RESET;
  logic [1:0] GRANT;
  logic       BUSY;
  logic       BEAT_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  axi_write_arbiter_if #(.NUM_M(2), .ADDR_W(16), .DATA_W(32)) bus ();

  axi_write_arbiter #(.NUM_M(2), .ADDR_W(16), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .GRANT    (GRANT),
    .BUSY     (BUSY),
    .BEAT_ERR (BEAT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    bus.M_AWADDR  = '0;
    bus.M_AWCTL   = '0;
    bus.M_AWVALID = '0;
    bus.M_WDATA   = '0;
    bus.M_WLAST   = '0;
    bus.M_WVALID  = '0;
    bus.M_BREADY  = '0;
    bus.S_AWREADY = 1'b0;
    bus.S_WREADY  = 1'b0;
    bus.S_BRESP   = 2'b00;
    bus.S_BVALID  = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Drives one transaction for master m from the current IDLE cycle to just after its B handshake.
  task automatic run_txn(input int m, input logic [15:0] addr, input logic [7:0] len,
                         input int nbeats, input logic [1:0] sresp,
                         input int stall_at, input int stall_n,
                         output int aw_wait, output int nb, output int data_bad,
                         output logic [1:0] bresp, output int err_seen, output int tmo);
    logic [1:0]  mask;
    logic [3:0]  bmask;
    logic [31:0] exp_d;
    logic        done;
    int          stall_left;
    mask  = 2'(1 << m);
    bmask = 4'(3 << (2 * m));
    aw_wait = -1; nb = 0; data_bad = 0; bresp = 2'bxx; err_seen = 0; tmo = 0;

    bus.M_AWADDR[m*16 +: 16] = addr;
    bus.M_AWCTL[m*13 +: 13]  = {len, 3'd2, 2'd1};
    bus.M_AWVALID[m]         = 1'b1;
    bus.S_AWREADY            = 1'b1;
    bus.S_WREADY             = 1'b1;
    done = 1'b0;
    for (int g = 0; g < 20 && !done; g++) begin
      @(negedge CLK);
      err_seen += int'(BEAT_ERR);
      if (((bus.M_AWREADY | bus.M_WREADY | bus.M_BVALID) & ~mask) !== 2'b00) data_bad++;
      if (bus.S_AWVALID === 1'b1 && bus.S_AWREADY === 1'b1) begin
        done    = 1'b1;
        aw_wait = g;
        if (bus.S_AWADDR !== addr || bus.S_AWCTL !== {len, 3'd2, 2'd1} ||
            bus.M_AWREADY[m] !== 1'b1 || GRANT !== mask) data_bad++;
      end
      @(posedge CLK); #1;
    end
    bus.M_AWVALID[m] = 1'b0;
    if (!done) tmo++;

    done = 1'b0;
    stall_left = stall_n;
    for (int g = 0; g < 40 && !done; g++) begin
      exp_d = 32'hD000_0000 + 32'(m * 256 + nb);
      bus.M_WVALID[m]          = 1'b1;
      bus.M_WDATA[m*32 +: 32]  = exp_d;
      bus.M_WLAST[m]           = (nb == nbeats - 1);
      bus.S_WREADY             = !(nb == stall_at && stall_left > 0);
      @(negedge CLK);
      err_seen += int'(BEAT_ERR);
      if (((bus.M_AWREADY | bus.M_WREADY | bus.M_BVALID) & ~mask) !== 2'b00) data_bad++;
      if (GRANT !== mask || bus.M_WREADY[m] !== bus.S_WREADY) data_bad++;
      if (!bus.S_WREADY) begin
        stall_left--;
      end else if (bus.S_WVALID === 1'b1) begin
        if (bus.S_WDATA !== exp_d || bus.S_WLAST !== (nb == nbeats - 1)) data_bad++;
        if (bus.S_WLAST === 1'b1) done = 1'b1;
        nb++;
      end
      @(posedge CLK); #1;
    end
    bus.M_WVALID[m] = 1'b0;
    bus.M_WLAST[m]  = 1'b0;
    bus.S_WREADY    = 1'b1;
    if (!done) tmo++;

    bus.S_BVALID    = 1'b1;
    bus.S_BRESP     = sresp;
    bus.M_BREADY[m] = 1'b1;
    done = 1'b0;
    for (int g = 0; g < 20 && !done; g++) begin
      @(negedge CLK);
      err_seen += int'(BEAT_ERR);
      if (((bus.M_AWREADY | bus.M_WREADY | bus.M_BVALID) & ~mask) !== 2'b00) data_bad++;
      if (GRANT !== mask || (bus.M_BRESP & ~bmask) !== 4'b0000) data_bad++;
      if (bus.M_BVALID[m] === 1'b1 && bus.S_BREADY === 1'b1) begin
        done  = 1'b1;
        bresp = bus.M_BRESP[m*2 +: 2];
      end
      @(posedge CLK); #1;
    end
    bus.S_BVALID    = 1'b0;
    bus.S_BRESP     = 2'b00;
    bus.M_BREADY[m] = 1'b0;
    if (!done) tmo++;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1'b1;
    bus.M_AWVALID = 2'b10;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if (GRANT !== 2'b00 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_grant_busy: got grant=%b busy=%b exp 00/0", GRANT, BUSY);
    end
    n_tests++;
    if (BEAT_ERR !== 1'b0) begin
      n_fail++; $display("FAIL reset_beat_err: got %b exp 0", BEAT_ERR);
    end
    n_tests++;
    if ({bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY, bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID} !== 9'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b exp 0",
        {bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY, bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID});
    end
    n_tests++;
    if (bus.M_BRESP !== 4'b0 || bus.S_AWADDR !== 16'h0 || bus.S_AWCTL !== 13'h0 || bus.S_WDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_payload: got bresp=%h awaddr=%h awctl=%h wdata=%h exp 0",
        bus.M_BRESP, bus.S_AWADDR, bus.S_AWCTL, bus.S_WDATA);
    end
    @(posedge CLK); #1;
    bus.M_AWVALID = 2'b00;
    RESET = 1'b0;
  endtask

  task automatic test_single();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    run_txn(0, 16'h0040, 8'd3, 4, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || tmo !== 0) begin
      n_fail++; $display("FAIL single_aw_latency: got wait=%0d tmo=%0d exp 1/0", aw_wait, tmo);
    end
    n_tests++;
    if (nb !== 4 || data_bad !== 0) begin
      n_fail++; $display("FAIL single_beats: got beats=%0d bad=%0d exp 4/0", nb, data_bad);
    end
    n_tests++;
    if (bresp !== 2'b00 || err_seen !== 0) begin
      n_fail++; $display("FAIL single_bresp: got bresp=%b err=%0d exp 00/0", bresp, err_seen);
    end
    @(negedge CLK);
    n_tests++;
    if (GRANT !== 2'b00 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got grant=%b busy=%b exp 00/0", GRANT, BUSY);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_simultaneous();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    apply_reset();
    bus.M_AWADDR[31:16] = 16'h1100;
    bus.M_AWCTL[25:13]  = {8'd1, 3'd2, 2'd1};
    bus.M_AWVALID[1]    = 1'b1;
    run_txn(0, 16'h0200, 8'd1, 2, 2'b01, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0 || bresp !== 2'b01) begin
      n_fail++; $display("FAIL simul_m0_first: got wait=%0d bad=%0d tmo=%0d bresp=%b exp 1/0/0/01",
        aw_wait, data_bad, tmo, bresp);
    end
    run_txn(1, 16'h1100, 8'd1, 2, 2'b11, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0 || bresp !== 2'b11 || nb !== 2) begin
      n_fail++; $display("FAIL simul_m1_next: got wait=%0d bad=%0d tmo=%0d bresp=%b beats=%0d exp 1/0/0/11/2",
        aw_wait, data_bad, tmo, bresp, nb);
    end
    run_txn(0, 16'h0300, 8'd0, 1, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    bus.M_AWADDR[15:0] = 16'h0400;
    bus.M_AWCTL[12:0]  = {8'd0, 3'd2, 2'd1};
    bus.M_AWVALID[0]   = 1'b1;
    run_txn(1, 16'h1200, 8'd0, 1, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL simul_alternate_m1_wins: got wait=%0d bad=%0d tmo=%0d exp 1/0/0",
        aw_wait, data_bad, tmo);
    end
    run_txn(0, 16'h0400, 8'd0, 1, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL simul_alternate_m0_after: got wait=%0d bad=%0d tmo=%0d exp 1/0/0",
        aw_wait, data_bad, tmo);
    end
  endtask

  task automatic test_mid_request();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    fork
      run_txn(0, 16'h0500, 8'd3, 4, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
      begin
        repeat (3) @(posedge CLK);
        #1;
        bus.M_AWADDR[31:16] = 16'h1500;
        bus.M_AWCTL[25:13]  = {8'd3, 3'd2, 2'd1};
        bus.M_AWVALID[1]    = 1'b1;
      end
    join
    n_tests++;
    if (data_bad !== 0 || tmo !== 0 || nb !== 4) begin
      n_fail++; $display("FAIL mid_m0_unaffected: got bad=%0d tmo=%0d beats=%0d exp 0/0/4", data_bad, tmo, nb);
    end
    run_txn(1, 16'h1500, 8'd3, 4, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0 || nb !== 4) begin
      n_fail++; $display("FAIL mid_m1_pending_grant: got wait=%0d bad=%0d tmo=%0d beats=%0d exp 1/0/0/4",
        aw_wait, data_bad, tmo, nb);
    end
  endtask

  task automatic test_wstall();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    run_txn(0, 16'h0600, 8'd3, 4, 2'b00, 2, 3, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (nb !== 4 || data_bad !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL wstall_beats: got beats=%0d bad=%0d tmo=%0d exp 4/0/0", nb, data_bad, tmo);
    end
    n_tests++;
    if (bresp !== 2'b00) begin
      n_fail++; $display("FAIL wstall_bresp: got %b exp 00", bresp);
    end
  endtask

  task automatic test_reset_mid_burst();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    bus.M_AWADDR[15:0] = 16'h0700;
    bus.M_AWCTL[12:0]  = {8'd7, 3'd2, 2'd1};
    bus.M_AWVALID[0]   = 1'b1;
    bus.S_AWREADY      = 1'b1;
    bus.S_WREADY       = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    bus.M_AWVALID[0]   = 1'b0;
    bus.M_WVALID[0]    = 1'b1;
    bus.M_WDATA[31:0]  = 32'hBEEF_0000;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (BUSY !== 1'b1 || GRANT !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_in_w: got busy=%b grant=%b exp 1/01", BUSY, GRANT);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    clear_inputs();
    @(negedge CLK);
    n_tests++;
    if (GRANT !== 2'b00 || BUSY !== 1'b0 ||
        {bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY, bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID} !== 9'b0) begin
      n_fail++; $display("FAIL rstmid_abort: got grant=%b busy=%b hs=%b exp 00/0/0", GRANT, BUSY,
        {bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY, bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID});
    end
    @(posedge CLK); #1;
    bus.M_AWADDR[31:16] = 16'h1700;
    bus.M_AWCTL[25:13]  = {8'd0, 3'd2, 2'd1};
    bus.M_AWVALID[1]    = 1'b1;
    run_txn(0, 16'h0710, 8'd0, 1, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL rstmid_m0_wins: got wait=%0d bad=%0d tmo=%0d exp 1/0/0", aw_wait, data_bad, tmo);
    end
    run_txn(1, 16'h1700, 8'd0, 1, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (aw_wait !== 1 || data_bad !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL rstmid_m1_drain: got wait=%0d bad=%0d tmo=%0d exp 1/0/0", aw_wait, data_bad, tmo);
    end
  endtask

  task automatic test_beat_check();
    int aw_wait, nb, data_bad, err_seen, tmo;
    logic [1:0] bresp;
    logic [1:0] exp_bresp;
    int         exp_err;
`ifdef AXI_ARB_BEAT_CHECK_EN
    exp_bresp = 2'b10;
    exp_err   = 1;
`else
    exp_bresp = 2'b00;
    exp_err   = 0;
`endif
    run_txn(0, 16'h0800, 8'd3, 3, 2'b00, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (nb !== 3 || tmo !== 0 || data_bad !== 0) begin
      n_fail++; $display("FAIL beatchk_short_burst: got beats=%0d tmo=%0d bad=%0d exp 3/0/0", nb, tmo, data_bad);
    end
    n_tests++;
    if (bresp !== exp_bresp) begin
      n_fail++; $display("FAIL beatchk_bresp: got %b exp %b", bresp, exp_bresp);
    end
    n_tests++;
    if (err_seen !== exp_err) begin
      n_fail++; $display("FAIL beatchk_pulse: got %0d cycles exp %0d", err_seen, exp_err);
    end
    @(negedge CLK);
    n_tests++;
    if (BEAT_ERR !== 1'b0) begin
      n_fail++; $display("FAIL beatchk_pulse_end: got %b exp 0", BEAT_ERR);
    end
    @(posedge CLK); #1;
    run_txn(0, 16'h0810, 8'd1, 2, 2'b01, -1, 0, aw_wait, nb, data_bad, bresp, err_seen, tmo);
    n_tests++;
    if (bresp !== 2'b01 || err_seen !== 0 || tmo !== 0) begin
      n_fail++; $display("FAIL beatchk_cleared: got bresp=%b err=%0d tmo=%0d exp 01/0/0", bresp, err_seen, tmo);
    end
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_mid_request();
    test_wstall();
    test_reset_mid_burst();
    test_beat_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Shares one AXI write slave (AW/W/B channels, 16-bit address, 32-bit data) between NUM_M write masters.
- Round-robin arbitration on AW requests. The winner owns all three channels until its B handshake completes.
- Sits between the VIP master agents / DMA engines and the single write-channel slave port.

Parameters:
- NUM_M, 2, number of masters (2..4)
- ADDR_W, 16, AWADDR width
- DATA_W, 32, WDATA width

Ports:
- CLK  input  1  clock; all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- M_AWADDR  input  NUM_M*ADDR_W  per-master AW address, master i at bits [i*ADDR_W +: ADDR_W]
- M_AWCTL  input  NUM_M*13  per-master {AWLEN[7:0],AWSIZE[2:0],AWBURST[1:0]}
- M_AWVALID  input  NUM_M  per-master AW valid
- M_AWREADY  output  NUM_M  per-master AW ready
- M_WDATA  input  NUM_M*DATA_W  per-master write data
- M_WLAST  input  NUM_M  per-master last beat
- M_WVALID  input  NUM_M  per-master W valid
- M_WREADY  output  NUM_M  per-master W ready
- M_BRESP  output  NUM_M*2  per-master response
- M_BVALID  output  NUM_M  per-master B valid
- M_BREADY  input  NUM_M  per-master B ready
- S_AWADDR/S_AWCTL  output  ADDR_W/13  granted master's AW payload
- S_AWVALID  output  1  AW valid to slave
- S_AWREADY  input  1  AW ready from slave
- S_WDATA  output  DATA_W  granted write data
- S_WLAST  output  1  granted last beat
- S_WVALID  output  1  W valid to slave
- S_WREADY  input  1  W ready from slave
- S_BRESP  input  2  slave response
- S_BVALID  input  1  slave B valid
- S_BREADY  output  1  B ready to slave
- GRANT  output  NUM_M  one-hot current owner, 0 when idle
- BUSY  output  1  high in any state other than IDLE
- BEAT_ERR  output  1  beat-count mismatch flag (see Optional Feature)

Behaviour:
- FSM states: IDLE -> AW -> W -> B -> IDLE. State is registered and GRANT is registered.
- Reset values:
  - state = IDLE, GRANT = 0, BUSY = 0, BEAT_ERR = 0.
  - rr_ptr = NUM_M-1, so master 0 wins the first contention.
  - All S_*VALID, S_BREADY, M_*READY and M_BVALID = 0.
  - M_BRESP = 0, S_AWADDR/S_AWCTL/S_WDATA = 0.
- IDLE: if any M_AWVALID is set, pick the first requester searching upward from rr_ptr+1 (mod NUM_M). Load GRANT one-hot and go to AW on the next edge. The slave sees no traffic in IDLE.
- AW: S_AWVALID/S_AWADDR/S_AWCTL = granted master's signals (combinational mux). M_AWREADY[g] = S_AWREADY; all other M_AWREADY = 0. On S_AWVALID & S_AWREADY go to W.
- W: S_WVALID/S_WDATA/S_WLAST = granted master's signals. M_WREADY[g] = S_WREADY. On a handshake with S_WLAST = 1 go to B.
- B: M_BVALID[g] = S_BVALID, M_BRESP[g] = S_BRESP, S_BREADY = M_BREADY[g]. On the handshake: rr_ptr <= g, GRANT <= 0, go to IDLE.
- Latency: a request at IDLE in cycle n drives S_AWVALID at n+1. Minimum transaction length is 4 cycles plus the slave's wait states. There is one IDLE bubble between back-to-back grants.
- Non-granted masters:
  - Ready/valid outputs stay 0; they stall on AW.
  - A request arriving mid-transaction is held pending and is not dropped.
- Simultaneous requests: round-robin guarantees any requester waits at most NUM_M-1 transactions.
- A new AWVALID arriving in the same cycle as the B handshake is evaluated in the following IDLE cycle.
- RESET asserted mid-burst aborts the transaction immediately and restores all reset values. Slave-side recovery is the bench's responsibility.

Optional Feature:
- Macro: AXI_ARB_BEAT_CHECK_EN.
- When defined:
  - AWLEN is latched on the AW handshake and W handshakes are counted from 0.
  - At the WLAST handshake, count != AWLEN sets a sticky internal error for the current transaction.
  - In B state, M_BRESP[g] is forced to 2'b10 (SLVERR) when the error is set.
  - BEAT_ERR pulses high for one cycle on the B handshake.
  - The error clears on return to IDLE.
- When undefined: no counter is built, BEAT_ERR is tied to 0, and BRESP passes through unmodified.

Test Plan:
- M0 single burst, AWADDR=0x0040, AWLEN=3, slave always ready -> S_AWVALID at cycle 1 after request, 4 W beats forwarded, GRANT=01 until B handshake, BRESP=00 returned to M0 only.
- M0 and M1 request the same cycle after reset -> M0 served first, M1 served next. Repeat the simultaneous request -> M1 wins (alternation).
- M1 requests during M0's W phase -> M_AWREADY[1] stays 0 throughout, M1 granted in the IDLE cycle after M0's B handshake.
- Slave deasserts S_WREADY on beat 2 for 3 cycles -> M_WREADY[g] mirrors it, no beat lost or duplicated, WDATA order preserved.
- RESET pulsed during the W phase of AWLEN=7 -> next cycle GRANT=0, BUSY=0, all valids 0. The next request is granted to master 0.
- With AXI_ARB_BEAT_CHECK_EN: AWLEN=3 but WLAST sent on beat 2 (count 2) -> M_BRESP=10, BEAT_ERR pulses 1 cycle. Without the macro -> slave BRESP passes through, BEAT_ERR=0.
